rx_iq_serializer: RTL and testbench

- Parametrised successor to the Rx FIFO byte-serialiser.
- Converts I/Q samples from up to NR receivers into a byte stream for the Ethernet Rx FIFO, MSB first, I before Q.
- Sends a primary receiver followed by any receivers flagged in Sync, in ascending index order.
- Adds configurable sample width, FIFO backpressure stall inside a burst, per-receiver sample acknowledge and an overflow counter.

---
 rtl/rx_iq_serializer.sv | 157 +++++++++++++++
 tb/tb_rx_iq_serializer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_iq_serializer.sv
// rx_iq_serializer
// Serialises I/Q samples from up to NR receivers into a byte stream for the
// Ethernet Rx FIFO. Each burst sends the primary receiver first, then every
// receiver flagged in Sync in ascending index order. Each component is sent
// MSB first, with I before Q. Bursts stall while the FIFO reports full, and a
// full FIFO seen while idle triggers a FIFO clear and bumps a saturating counter.
//
// Ports
//   clock          system clock, rising edge
//   reset          synchronous, active-low (0 = reset)
//   Rx_number      primary receiver index (sampled in INIT only)
//   Sync           extra receivers to send (sampled in INIT only)
//   iq_data        flattened {I,Q} per receiver, receiver k at [k*2*SW +: 2*SW]
//   spd_rdy        per-receiver sample-ready levels
//   fifo_full      Rx FIFO full
//   Rx_fifo_empty  Rx FIFO empty
//   wrenable       FIFO write strobe, qualifies data_out
//   data_out       serialised byte
//   sample_ack     one-cycle pulse when receiver k's sample is captured
//   convert_state  idle and waiting for new primary data
//   fifo_clear     FIFO clear request
//   overflow_count saturating count of FIFO-clear events
module rx_iq_serializer #(
  parameter int NR           = 8,
  parameter int SAMPLE_BYTES = 3
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [$clog2(NR)-1:0]           Rx_number,
  input  logic [NR-1:0]                   Sync,
  input  logic [NR*2*SAMPLE_BYTES*8-1:0]  iq_data,
  input  logic [NR-1:0]                   spd_rdy,
  input  logic                            fifo_full,
  input  logic                            Rx_fifo_empty,
  output logic                            wrenable,
  output logic [7:0]                      data_out,
  output logic [NR-1:0]                   sample_ack,
  output logic                            convert_state,
  output logic                            fifo_clear,
  output logic [7:0]                      overflow_count
);

  localparam int SW = 8 * SAMPLE_BYTES;
  localparam int PW = 2 * SW;
  localparam int NB = 2 * SAMPLE_BYTES;
  localparam int RW = $clog2(NR);
  localparam int CW = $clog2(NB);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_IDLE      = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_DROP = 3'd3,
    S_CLEAR     = 3'd4
  } state_t;

  state_t          state;
  logic [RW-1:0]   rx_sel;
  logic [NR-1:0]   pend;
  logic [CW-1:0]   byte_cnt;
  logic [PW-1:0]   shift;

  logic [RW-1:0]   sel_init;
  logic [RW-1:0]   nxt_k;
  logic [PW-1:0]   iq_sel;
  logic [PW-1:0]   iq_nxt;

  function automatic logic [NR-1:0] onehot(input logic [RW-1:0] idx);
    onehot = NR'(1) << idx;
  endfunction

  // Lowest set bit wins, which gives ascending receiver order.
  function automatic logic [RW-1:0] lowest_set(input logic [NR-1:0] v);
    lowest_set = '0;
    for (int i = NR - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = RW'(i);
    end
  endfunction

  // Out-of-range primary index falls back to receiver 0.
  assign sel_init = (32'(Rx_number) < NR) ? Rx_number : '0;
  assign nxt_k    = lowest_set(pend);
  assign iq_sel   = iq_data[int'(rx_sel) * PW +: PW];
  assign iq_nxt   = iq_data[int'(nxt_k)  * PW +: PW];

  assign convert_state = (state == S_IDLE) && !spd_rdy[rx_sel];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= S_INIT;
      wrenable       <= 1'b0;
      data_out       <= 8'h00;
      sample_ack     <= '0;
      overflow_count <= 8'h00;
      fifo_clear     <= 1'b1;
      rx_sel         <= '0;
      pend           <= '0;
      byte_cnt       <= '0;
    end else begin
      wrenable   <= 1'b0;
      sample_ack <= '0;
      case (state)
        S_INIT: begin
          fifo_clear <= 1'b0;
          rx_sel     <= sel_init;
          // The primary is never queued a second time through Sync.
          pend       <= Sync & ~onehot(sel_init);
          state      <= S_IDLE;
        end
        S_IDLE: begin
          if (fifo_full) begin
            if (overflow_count != 8'hFF) overflow_count <= overflow_count + 8'd1;
            fifo_clear <= 1'b1;
            state      <= S_CLEAR;
          end else if (spd_rdy[rx_sel] && ((spd_rdy & pend) == pend)) begin
            shift      <= iq_sel;
            sample_ack <= onehot(rx_sel);
            byte_cnt   <= '0;
            state      <= S_SEND;
          end
        end
        S_SEND: begin
          // A full FIFO freezes shift and byte_cnt so nothing is lost or repeated.
          if (!fifo_full) begin
            wrenable <= 1'b1;
            data_out <= shift[PW-1 -: 8];
            if (byte_cnt == LAST_BYTE) begin
              if (pend != '0) begin
                // Load the next receiver on the last byte so its first byte
                // follows without a gap cycle.
                shift      <= iq_nxt;
                sample_ack <= onehot(nxt_k);
                pend       <= pend & ~onehot(nxt_k);
                byte_cnt   <= '0;
              end else begin
                state <= S_WAIT_DROP;
              end
            end else begin
              shift    <= shift << 8;
              byte_cnt <= byte_cnt + CW'(1);
            end
          end
        end
        S_WAIT_DROP: begin
          if (!spd_rdy[rx_sel]) state <= S_INIT;
        end
        S_CLEAR: begin
          fifo_clear <= 1'b1;
          if (Rx_fifo_empty) state <= S_INIT;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_iq_serializer.sv
// Self-checking bench for rx_iq_serializer: a 4-receiver 3-byte instance and
// a 4-receiver 2-byte instance. Expected bytes are queued when stimulus is
// applied and compared as the DUT writes them.
module tb_rx_iq_serializer;

  logic               clock;
  logic               reset, reset2;
  logic [1:0]         Rx_number;
  logic [3:0]         Sync;
  logic [4*48-1:0]    iq_data;
  logic [4*32-1:0]    iq_data2;
  logic [3:0]         spd_rdy;
  logic               fifo_full, Rx_fifo_empty;

  logic               wrenable, wrenable2;
  logic [7:0]         data_out, data_out2;
  logic [3:0]         sample_ack, sample_ack2;
  logic               convert_state, convert_state2;
  logic               fifo_clear, fifo_clear2;
  logic [7:0]         overflow_count, overflow_count2;

  rx_iq_serializer #(.NR(4), .SAMPLE_BYTES(3)) dut (
    .clock(clock), .reset(reset), .Rx_number(Rx_number), .Sync(Sync),
    .iq_data(iq_data), .spd_rdy(spd_rdy), .fifo_full(fifo_full),
    .Rx_fifo_empty(Rx_fifo_empty), .wrenable(wrenable), .data_out(data_out),
    .sample_ack(sample_ack), .convert_state(convert_state),
    .fifo_clear(fifo_clear), .overflow_count(overflow_count)
  );

  rx_iq_serializer #(.NR(4), .SAMPLE_BYTES(2)) dut2 (
    .clock(clock), .reset(reset2), .Rx_number(Rx_number), .Sync(Sync),
    .iq_data(iq_data2), .spd_rdy(spd_rdy), .fifo_full(fifo_full),
    .Rx_fifo_empty(Rx_fifo_empty), .wrenable(wrenable2), .data_out(data_out2),
    .sample_ack(sample_ack2), .convert_state(convert_state2),
    .fifo_clear(fifo_clear2), .overflow_count(overflow_count2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];
  int         wr_cyc[$];
  int         wr2_cyc[$];
  logic [3:0] ack_log[$];
  logic [3:0] ack2_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard for the 3-byte instance.
  always @(negedge clock) begin
    logic [7:0] e;
    if (wrenable === 1'b1) begin
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("extra_wr", 32'(wrenable), 32'(0));
      else begin
        e = exp_q.pop_front();
        chk("byte", 32'(data_out), 32'(e));
      end
    end
    if (sample_ack !== 4'b0000 && reset === 1'b1) ack_log.push_back(sample_ack);
  end

  // Scoreboard for the 2-byte instance.
  always @(negedge clock) begin
    logic [7:0] e;
    if (wrenable2 === 1'b1) begin
      wr2_cyc.push_back(cyc);
      if (exp2_q.size() == 0) chk("extra_wr2", 32'(wrenable2), 32'(0));
      else begin
        e = exp2_q.pop_front();
        chk("byte2", 32'(data_out2), 32'(e));
      end
    end
    if (sample_ack2 !== 4'b0000 && reset2 === 1'b1) ack2_log.push_back(sample_ack2);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_iq(input int k, input logic [23:0] i_v, input logic [23:0] q_v);
    iq_data[k*48 +: 48] = {i_v, q_v};
  endtask

  task automatic push_rx(input logic [23:0] i_v, input logic [23:0] q_v);
    for (int b = 0; b < 3; b++) exp_q.push_back(i_v[23-8*b -: 8]);
    for (int b = 0; b < 3; b++) exp_q.push_back(q_v[23-8*b -: 8]);
  endtask

  task automatic restart(input logic [1:0] rn, input logic [3:0] sy);
    Rx_number = rn;
    Sync      = sy;
    spd_rdy   = 4'b0000;
    fifo_full = 1'b0;
    reset     = 1'b0;
    tick();
    reset     = 1'b1;
    tick();
    wr_cyc.delete();
    ack_log.delete();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    chk("drain", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic wait_drain2(input int budget);
    int n;
    n = 0;
    while (exp2_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    chk("drain2", 32'(exp2_q.size()), 32'(0));
  endtask

  task automatic chk_span(input string tag, input int nwr, input int span);
    chk({tag, "_nwr"}, 32'(wr_cyc.size()), 32'(nwr));
    if (wr_cyc.size() > 0) chk({tag, "_span"}, 32'(wr_cyc[$] - wr_cyc[0]), 32'(span));
  endtask

  initial begin
    logic [23:0] iv, qv;
    logic [3:0]  ord_ack [4];

    reset = 1'b0; reset2 = 1'b0;
    Rx_number = 2'd0; Sync = 4'b0000; spd_rdy = 4'b0000;
    fifo_full = 1'b0; Rx_fifo_empty = 1'b0;
    iq_data = '0; iq_data2 = '0;

    // Reset state
    tick(); tick();
    chk("rst_wrenable", 32'(wrenable), 32'(0));
    chk("rst_data_out", 32'(data_out), 32'(0));
    chk("rst_ack",      32'(sample_ack), 32'(0));
    chk("rst_ovf",      32'(overflow_count), 32'(0));
    chk("rst_clear",    32'(fifo_clear), 32'(1));

    // Single primary receiver, no Sync
    set_iq(1, 24'hA1B2C3, 24'hD4E5F6);
    restart(2'd1, 4'b0000);
    chk("init_clear", 32'(fifo_clear), 32'(0));
    chk("conv_idle", 32'(convert_state), 32'(1));
    push_rx(24'hA1B2C3, 24'hD4E5F6);
    spd_rdy = 4'b0010;
    tick();
    chk("t1_ack", 32'(sample_ack), 32'(4'b0010));
    chk("t1_first_wr", 32'(wrenable), 32'(0));
    wait_drain(40);
    chk_span("t1", 6, 5);
    chk("t1_ack_cnt", 32'(ack_log.size()), 32'(1));
    repeat (4) tick();
    chk("t1_wait_drop_conv", 32'(convert_state), 32'(0));
    chk("t1_no_rewrite", 32'(wr_cyc.size()), 32'(6));
    spd_rdy = 4'b0000;
    tick(); tick();
    chk("t1_back_idle", 32'(convert_state), 32'(1));

    // Primary 2 plus Sync 1011 -> order 2,0,1,3
    for (int k = 0; k < 4; k++) begin
      iv = 24'(k << 20) | 24'h010000 | 24'(k << 12) | 24'h000200 | 24'(k << 4) | 24'h000003;
      qv = 24'(k << 20) | 24'h040000 | 24'(k << 12) | 24'h000500 | 24'(k << 4) | 24'h000006;
      set_iq(k, iv, qv);
    end
    restart(2'd2, 4'b1011);
    exp_q.delete();
    foreach (ord_ack[j]) ord_ack[j] = 4'b0000;
    ord_ack[0] = 4'b0100; ord_ack[1] = 4'b0001; ord_ack[2] = 4'b0010; ord_ack[3] = 4'b1000;
    for (int j = 0; j < 4; j++) begin
      int k;
      k = (j == 0) ? 2 : (j == 1) ? 0 : (j == 2) ? 1 : 3;
      iv = 24'(k << 20) | 24'h010000 | 24'(k << 12) | 24'h000200 | 24'(k << 4) | 24'h000003;
      qv = 24'(k << 20) | 24'h040000 | 24'(k << 12) | 24'h000500 | 24'(k << 4) | 24'h000006;
      push_rx(iv, qv);
    end
    spd_rdy = 4'b1111;
    wait_drain(80);
    chk_span("t2", 24, 23);
    chk("t2_ack_cnt", 32'(ack_log.size()), 32'(4));
    for (int j = 0; j < 4; j++) begin
      if (j < ack_log.size()) chk("t2_ack_order", 32'(ack_log[j]), 32'(ord_ack[j]));
    end

    // Backpressure: fifo_full for 3 cycles after the 2nd byte
    set_iq(1, 24'hA1B2C3, 24'hD4E5F6);
    restart(2'd1, 4'b0000);
    push_rx(24'hA1B2C3, 24'hD4E5F6);
    spd_rdy = 4'b0010;
    tick(); tick(); tick();
    chk("t3_second_byte", 32'(data_out), 32'(8'hB2));
    fifo_full = 1'b1;
    tick(); tick(); tick();
    chk("t3_stalled", 32'(wrenable), 32'(0));
    fifo_full = 1'b0;
    wait_drain(40);
    chk_span("t3", 6, 8);

    // Reset during the 3rd byte aborts the burst
    restart(2'd1, 4'b0000);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
    spd_rdy = 4'b0010;
    tick(); tick(); tick(); tick();
    chk("t6_third_byte", 32'(data_out), 32'(8'hC3));
    reset = 1'b0;
    spd_rdy = 4'b0000;
    tick();
    chk("t6_abort_wr", 32'(wrenable), 32'(0));
    chk("t6_abort_clear", 32'(fifo_clear), 32'(1));
    reset = 1'b1;
    tick();
    chk("t6_init_clear", 32'(fifo_clear), 32'(0));
    chk("t6_partial", 32'(exp_q.size()), 32'(0));
    wr_cyc.delete();
    push_rx(24'hA1B2C3, 24'hD4E5F6);
    spd_rdy = 4'b0010;
    wait_drain(40);
    chk_span("t6", 6, 5);
    spd_rdy = 4'b0000;

    // FIFO full while idle -> clear sequence and overflow count
    restart(2'd0, 4'b0000);
    fifo_full = 1'b1;
    tick();
    fifo_full = 1'b0;
    chk("t4_clear_on", 32'(fifo_clear), 32'(1));
    chk("t4_ovf1", 32'(overflow_count), 32'(1));
    tick(); tick();
    chk("t4_clear_hold", 32'(fifo_clear), 32'(1));
    Rx_fifo_empty = 1'b1;
    tick();
    chk("t4_clear_in_init", 32'(fifo_clear), 32'(1));
    tick();
    chk("t4_clear_off", 32'(fifo_clear), 32'(0));
    chk("t4_conv", 32'(convert_state), 32'(1));
    fifo_full = 1'b1;
    for (int n = 0; n < 254; n++) begin
      tick(); tick(); tick();
    end
    chk("t4_ovf255", 32'(overflow_count), 32'(255));
    for (int n = 0; n < 45; n++) begin
      tick(); tick(); tick();
    end
    chk("t4_ovf_sat", 32'(overflow_count), 32'(255));
    fifo_full = 1'b0;
    Rx_fifo_empty = 1'b0;
    repeat (3) tick();
    chk("t4_no_write", 32'(wr_cyc.size()), 32'(0));

    // 2-byte instance; Sync changed mid-burst must not alter the burst
    reset = 1'b0;
    Rx_number = 2'd0; Sync = 4'b0000; spd_rdy = 4'b0000;
    iq_data2[0*32 +: 32] = 32'h1234_5678;
    iq_data2[1*32 +: 32] = 32'h9ABC_DEF0;
    iq_data2[2*32 +: 32] = 32'h1357_2468;
    iq_data2[3*32 +: 32] = 32'hCAFE_BEEF;
    reset2 = 1'b1;
    tick();
    exp2_q.push_back(8'h12); exp2_q.push_back(8'h34);
    exp2_q.push_back(8'h56); exp2_q.push_back(8'h78);
    spd_rdy = 4'b0001;
    tick();
    chk("t5_ack", 32'(sample_ack2), 32'(4'b0001));
    tick();
    Sync = 4'b1110;
    spd_rdy = 4'b1111;
    wait_drain2(40);
    repeat (6) tick();
    chk("t5_nwr", 32'(wr2_cyc.size()), 32'(4));
    if (wr2_cyc.size() > 0) chk("t5_span", 32'(wr2_cyc[$] - wr2_cyc[0]), 32'(3));
    chk("t5_ack_cnt", 32'(ack2_log.size()), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
